input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end conditioning stage feeding the microcoded state machine's primary inputs (A, B, C, D). The block synchronises WIDTH asynchronous raw inputs to Clock and debounces each one independently. It presents clean levels that connect directly to the state machine's input-select mux, and can optionally produce one-cycle rise and fall pulses. Its purpose is to stop bouncing or metastable inputs from causing the ROM-sequenced counter to branch spuriously.

## Interface
- WIDTH, 4: number of independent input channels; bit 0 is A, bit 3 is D.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised input must differ from its clean level before the clean level flips; legal range 2..65535.
- CW, $clog2(DEBOUNCE_CYCLES): counter width, derived; do not override.
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-low reset; sampled on posedge Clock.
- RawIn  input  WIDTH  asynchronous raw inputs.
- Clean  output  WIDTH  debounced level per channel; drives the state machine's A..D.
- Rise  output  WIDTH  one-cycle pulse when Clean[i] goes 0->1 (see Configuration).
- Fall  output  WIDTH  one-cycle pulse when Clean[i] goes 1->0 (see Configuration).
- Busy  output  1  high while any channel's counter is nonzero.

## Operation
- Per channel, a 2-flop synchroniser runs RawIn[i] -> Sync1[i] -> Sync2[i]. Only Sync2 is used downstream.
- Each channel runs a two-state FSM with a CW-bit counter Cnt[i]:
  - STABLE (Cnt=0, Sync2==Clean): stays in STABLE while they remain equal.
  - STABLE -> COUNTING when Sync2!=Clean; Cnt <= 1.
  - COUNTING with Sync2!=Clean and Cnt<DEBOUNCE_CYCLES-1: Cnt <= Cnt+1.
  - COUNTING with Sync2!=Clean and Cnt==DEBOUNCE_CYCLES-1: Clean <= Sync2; Cnt <= 0; -> STABLE.
  - COUNTING with Sync2==Clean (glitch ended early): Cnt <= 0; -> STABLE; Clean is unchanged.
- Rise[i]/Fall[i] are registered and asserted in the same cycle Clean[i] takes its new value. They are high for exactly one cycle and never both high on one channel.
- Busy = OR over all channels of (Cnt[i]!=0), combinational from registers.
- Channels are fully independent. Several channels may flip Clean in the same cycle, and each produces its own pulse.
- Reset (Reset==0 at a posedge): Sync1, Sync2, Clean, Cnt, Rise, Fall all go to 0, so Busy=0. This applies mid-count as well; any partial count is discarded. After reset is released, a channel whose RawIn is already high rises only after the full latency below.

## Timing
- Reset values: Clean=0, Rise=0, Fall=0, Busy=0.
- Latency: if RawIn[i] holds a new value from sampling edge k onward, then Sync2 holds it after edge k+1 and Clean/Rise/Fall update at edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+1 cycles after the first sampling edge.
- Rejection: a synchronised disturbance that lasts DEBOUNCE_CYCLES-1 cycles or fewer never changes Clean.
- Counter wrap cannot occur. Cnt is bounded at DEBOUNCE_CYCLES-1 and cleared on a flip.
- Clean is a pure register output with no combinational path from RawIn, so it is safe to feed the state machine's input mux in the same clock domain.

## Configuration
- INPUT_COND_EDGE_EN:
  - Defined: the Rise/Fall registers and logic are compiled in, with behaviour as above.
  - Undefined: Rise and Fall are tied to WIDTH'b0 and no edge registers are instantiated. Clean, Busy and latency are identical in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and WIDTH=4.
- Reset: hold Reset=0 for 3 cycles with RawIn=4'hF, then release -> during reset Clean=0, Rise=0, Busy=0; after release Clean=4'hF exactly 5 cycles after the first post-reset edge, with Rise=4'hF for one cycle.
- Clean transition: RawIn[0] goes 0->1 at edge k and holds -> Busy rises at k+2; Clean[0]=1 and Rise[0]=1 at k+5; Rise[0]=0 at k+6; Busy=0 at k+5.
- Glitch rejection: RawIn[1] pulses high for 3 cycles, then low -> Clean[1] stays 0, Rise[1] never asserts, and Cnt returns to 0 (Busy=0) once Sync2 returns low.
- Bounce: RawIn[2] toggles 1,0,1,0,1 on consecutive cycles, then holds 1 -> Clean[2] flips once, 5 cycles after the final 0->1, and Rise[2] pulses exactly once.
- Simultaneous and reset mid-count: RawIn=4'hA at edge k; assert Reset=0 at k+3 for one cycle -> Clean stays 0 and Busy=0 at k+4. With RawIn still 4'hA, Clean=4'hA and Rise=4'hA at k+4+5. Then drop RawIn to 0 -> Fall=4'hA for one cycle (zero in the no-INPUT_COND_EDGE_EN build).

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: per-channel 2-flop synchroniser and debounce FSM producing clean levels.
// Define INPUT_COND_EDGE_EN to compile in the registered Rise/Fall pulse outputs.
module input_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] RawIn,
  output logic [WIDTH-1:0] Clean,
  output logic [WIDTH-1:0] Rise,
  output logic [WIDTH-1:0] Fall,
  output logic             Busy
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_clean;
  state_t           r_state     [WIDTH];
  state_t           w_state_nxt [WIDTH];
  logic [CW-1:0]    r_cnt       [WIDTH];
  logic [CW-1:0]    w_cnt_nxt   [WIDTH];
  logic [WIDTH-1:0] w_clean_nxt;
  logic [WIDTH-1:0] w_cnt_nz;

  // Two-stage synchroniser; only r_sync2 is used by the debounce logic.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_sync1 <= {WIDTH{1'b0}};
      r_sync2 <= {WIDTH{1'b0}};
    end else begin
      r_sync1 <= RawIn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce state, counter and clean level registers for all channels.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_clean <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= ST_STABLE;
        r_cnt[i]   <= CNT_ZERO;
      end
    end else begin
      r_clean <= w_clean_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Next-state logic: a disagreement must persist DEBOUNCE_CYCLES cycles before Clean follows.
  always_comb begin
    w_clean_nxt = r_clean;
    for (int i = 0; i < WIDTH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_STABLE: begin
          if (r_sync2[i] != r_clean[i]) begin
            w_state_nxt[i] = ST_COUNTING;
            w_cnt_nxt[i]   = CNT_ONE;
          end else begin
            w_cnt_nxt[i]   = CNT_ZERO;
          end
        end
        ST_COUNTING: begin
          if (r_sync2[i] == r_clean[i]) begin
            w_state_nxt[i] = ST_STABLE;
            w_cnt_nxt[i]   = CNT_ZERO;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = ST_STABLE;
            w_cnt_nxt[i]   = CNT_ZERO;
            w_clean_nxt[i] = r_sync2[i];
          end else begin
            w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_STABLE;
          w_cnt_nxt[i]   = CNT_ZERO;
        end
      endcase
    end
  end

  // Busy reflects any channel with a partial count in progress.
  always_comb begin
    w_cnt_nz = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nz[i] = (r_cnt[i] != CNT_ZERO);
    end
  end

  assign Busy  = |w_cnt_nz;
  assign Clean = r_clean;

`ifdef INPUT_COND_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // Edge pulses land in the same cycle Clean takes its new value.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_rise <= {WIDTH{1'b0}};
      r_fall <= {WIDTH{1'b0}};
    end else begin
      r_rise <= w_clean_nxt & ~r_clean;
      r_fall <= ~w_clean_nxt & r_clean;
    end
  end

  assign Rise = r_rise;
  assign Fall = r_fall;
`else
  assign Rise = {WIDTH{1'b0}};
  assign Fall = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (DEBOUNCE_CYCLES=4): vector table, corner sequences,
// and randomized stimulus compared against a window-based reference model.
module tb_input_conditioner;

  localparam int W  = 4;
  localparam int DC = 4;
`ifdef INPUT_COND_EDGE_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  logic         Clock;
  logic         Reset;
  logic [W-1:0] RawIn;
  logic [W-1:0] Clean;
  logic [W-1:0] Rise;
  logic [W-1:0] Fall;
  logic         Busy;

  int checks = 0;
  int errors = 0;

  input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .RawIn (RawIn),
    .Clean (Clean),
    .Rise  (Rise),
    .Fall  (Fall),
    .Busy  (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: raw is seen two edges late; Clean flips once the last DC observations all disagree.
  logic [W-1:0] m_d1, m_d2;
  logic [W-1:0] m_obs[$];
  logic [W-1:0] m_clean, m_rise, m_fall;
  logic         m_busy;

  task automatic model_step();
    logic [W-1:0] s;
    logic [W-1:0] prev;
    bit           all_diff;
    if (!Reset) begin
      m_d1 = '0; m_d2 = '0; m_obs.delete();
      m_clean = '0; m_rise = '0; m_fall = '0; m_busy = 1'b0;
    end else begin
      s = m_d2; m_d2 = m_d1; m_d1 = RawIn;
      m_obs.push_back(s);
      if (m_obs.size() > DC) void'(m_obs.pop_front());
      prev = m_clean;
      for (int ch = 0; ch < W; ch++) begin
        if (m_obs.size() == DC) begin
          all_diff = 1'b1;
          foreach (m_obs[j]) if (m_obs[j][ch] == prev[ch]) all_diff = 1'b0;
          if (all_diff) m_clean[ch] = ~prev[ch];
        end
      end
      m_rise = EDGE_ON ? (m_clean & ~prev) : '0;
      m_fall = EDGE_ON ? (~m_clean & prev) : '0;
      m_busy = |(s ^ m_clean);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rst_n;
    logic [W-1:0] raw;
    logic [W-1:0] clean;
    logic         busy;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [W-1:0] raw, input logic [W-1:0] c,
                     input logic b, input logic [W-1:0] ri, input logic [W-1:0] fa);
    vec_t v;
    v.rst_n = r; v.raw = raw; v.clean = c; v.busy = b; v.rise = ri; v.fall = fa;
    tbl.push_back(v);
  endtask

  initial begin
    int rise_cnt;
    int hold [W];
    logic [W-1:0] bounce;
    logic [W-1:0] mask;
    Reset = 1'b0;
    RawIn = '0;

    // Reset with all inputs high, then release: flip 5 edges after first post-reset edge.
    add(1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0);
    add(1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0);
    add(1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0);
    add(1'b1, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0);
    add(1'b1, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0);
    add(1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 4'h0);
    add(1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 4'h0);
    add(1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 4'h0);
    add(1'b1, 4'hF, 4'hF, 1'b0, 4'hF, 4'h0);
    add(1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0);
    // Single-channel rise then fall on RawIn[0].
    add(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    add(1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    add(1'b1, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0);
    add(1'b1, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0);
    add(1'b1, 4'h1, 4'h0, 1'b1, 4'h0, 4'h0);
    add(1'b1, 4'h1, 4'h0, 1'b1, 4'h0, 4'h0);
    add(1'b1, 4'h1, 4'h0, 1'b1, 4'h0, 4'h0);
    add(1'b1, 4'h1, 4'h1, 1'b0, 4'h1, 4'h0);
    add(1'b1, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0);
    add(1'b1, 4'h0, 4'h1, 1'b0, 4'h0, 4'h0);
    add(1'b1, 4'h0, 4'h1, 1'b0, 4'h0, 4'h0);
    add(1'b1, 4'h0, 4'h1, 1'b1, 4'h0, 4'h0);
    add(1'b1, 4'h0, 4'h1, 1'b1, 4'h0, 4'h0);
    add(1'b1, 4'h0, 4'h1, 1'b1, 4'h0, 4'h0);
    add(1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h1);
    add(1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);

    foreach (tbl[i]) begin
      Reset = tbl[i].rst_n;
      RawIn = tbl[i].raw;
      tick();
      check($sformatf("table[%0d] clean/rise/fall/busy", i), {Clean, Rise, Fall, Busy},
            {tbl[i].clean, EDGE_ON ? tbl[i].rise : 4'h0, EDGE_ON ? tbl[i].fall : 4'h0, tbl[i].busy});
    end

    // Glitch on RawIn[1] lasting 3 cycles must be rejected.
    rise_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      RawIn = (i < 3) ? 4'h2 : 4'h0;
      tick();
      check("glitch clean", Clean, 4'h0);
      rise_cnt += Rise[1];
      if (i == 4) check("glitch busy mid", Busy, 1'b1);
      if (i == 5) check("glitch busy end", Busy, 1'b0);
    end
    check("glitch rise count", rise_cnt, 0);

    // Bounce on RawIn[2]: 1,0,1,0,1 then hold 1; flip 5 edges after last 0->1.
    bounce = 4'b0101;
    rise_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      RawIn = (i < 5) ? {1'b0, (i % 2 == 0), 2'b00} : 4'h4;
      tick();
      rise_cnt += Rise[2];
      if (i == 8) check("bounce clean before", Clean[2], 1'b0);
      if (i == 9) check("bounce clean after", Clean[2], 1'b1);
    end
    check("bounce rise count", rise_cnt, EDGE_ON ? 1 : 0);
    check("bounce other channels", Clean & ~4'h4, bounce & 4'h0);

    // Simultaneous channels with reset mid-count.
    mask = EDGE_ON ? 4'hA : 4'h0;
    Reset = 1'b0; RawIn = 4'h0; tick();
    Reset = 1'b1; tick();
    RawIn = 4'hA;
    tick(); tick(); tick();
    check("midrst busy before", Busy, 1'b1);
    Reset = 1'b0; tick();
    check("midrst busy in reset", Busy, 1'b0);
    Reset = 1'b1; tick();
    check("midrst clean k+4", Clean, 4'h0);
    check("midrst busy k+4", Busy, 1'b0);
    tick(); tick(); tick(); tick();
    check("midrst clean k+8", Clean, 4'h0);
    tick();
    check("midrst clean k+9", Clean, 4'hA);
    check("midrst rise k+9", Rise, mask);
    RawIn = 4'h0;
    tick(); tick(); tick(); tick(); tick();
    check("midrst clean before fall", Clean, 4'hA);
    tick();
    check("midrst clean after fall", Clean, 4'h0);
    check("midrst fall pulse", Fall, mask);
    check("midrst no rise", Rise, 4'h0);

    // Randomized per-channel hold lengths with occasional reset, checked against the model.
    for (int ch = 0; ch < W; ch++) hold[ch] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int ch = 0; ch < W; ch++) begin
        if (hold[ch] == 0) begin
          RawIn[ch] = $urandom_range(0, 1);
          hold[ch]  = $urandom_range(1, 7);
        end else begin
          hold[ch]--;
        end
      end
      Reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
      check("random clean/rise/fall/busy", {Clean, Rise, Fall, Busy}, {m_clean, m_rise, m_fall, m_busy});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
